// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_fifo : 8N1 UART receiver feeding a byte FIFO, pop-on-read data reg. |
// | Build option : UART_RX_PARITY_EN selects 8E1 framing and adds parity_err.   |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BAUD_RATE   = 1_000_000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        rxd,
    input  logic                        rd_en,
    input  logic                        clr_err,
    output logic [7:0]                  rdata,
    output logic                        rdata_valid,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        empty,
    output logic                        full,
    output logic                        overrun,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err,
`endif
    output logic                        frame_err
);

    localparam int c_div      = CLK_FREQ_HZ / BAUD_RATE;
    localparam int c_cnt_w    = $clog2(c_div);
    localparam int c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int c_cnt_bits = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0]    c_cnt_full = c_cnt_w'(c_div - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_half = c_cnt_w'(c_div / 2 - 1);
    localparam logic [c_cnt_bits-1:0] c_depth    = c_cnt_bits'(FIFO_DEPTH);

    localparam logic [2:0] c_st_arm    = 3'd0;
    localparam logic [2:0] c_st_idle   = 3'd1;
    localparam logic [2:0] c_st_start  = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_st_parity = 3'd5;
`endif

    logic                  r_sync1;
    logic                  r_rx_s;
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  w_tick;
    logic                  w_load_half;
    logic                  w_load_full;
    logic                  w_bit_clr;
    logic                  w_shift;
    logic                  w_stop_tick;
    logic                  w_push;
    logic                  w_set_fe;
    logic                  w_pop_ok;
    logic                  w_wr_ok;
    logic                  w_ovf;
    logic [c_cnt_bits-1:0] w_count_nxt;
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [7:0]            r_mem [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic                  w_par_sample;
    logic                  r_par_bad;
`endif

    // Two-flop synchroniser; reset to the idle level of the line.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= c_st_arm;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_arm:   if (r_rx_s)  w_state_nxt = c_st_idle;
            c_st_idle:  if (!r_rx_s) w_state_nxt = c_st_start;
            c_st_start: if (w_tick)  w_state_nxt = r_rx_s ? c_st_idle : c_st_data;
            c_st_data: begin
                if (w_tick && r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = c_st_parity;
`else
                    w_state_nxt = c_st_stop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            c_st_parity: if (w_tick) w_state_nxt = c_st_stop;
`endif
            // A low stop bit re-arms so a stuck-low line cannot start a new frame.
            c_st_stop:  if (w_tick)  w_state_nxt = r_rx_s ? c_st_idle : c_st_arm;
            default:    w_state_nxt = c_st_arm;
        endcase
    end

    always_comb begin
        w_load_half  = 1'b0;
        w_load_full  = 1'b0;
        w_bit_clr    = 1'b0;
        w_shift      = 1'b0;
        w_stop_tick  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            c_st_idle:  w_load_half = !r_rx_s;
            c_st_start: begin
                if (w_tick && !r_rx_s) begin
                    w_load_full = 1'b1;
                    w_bit_clr   = 1'b1;
                end
            end
            c_st_data: begin
                w_load_full = w_tick;
                w_shift     = w_tick;
            end
`ifdef UART_RX_PARITY_EN
            c_st_parity: begin
                w_load_full  = w_tick;
                w_par_sample = w_tick;
            end
`endif
            c_st_stop:  w_stop_tick = w_tick;
            default:    ;
        endcase
    end

    assign w_set_fe = w_stop_tick && !r_rx_s;
`ifdef UART_RX_PARITY_EN
    assign w_push   = w_stop_tick && r_rx_s && !r_par_bad;
`else
    assign w_push   = w_stop_tick && r_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            if (w_load_half)      r_cnt <= c_cnt_half;
            else if (w_load_full) r_cnt <= c_cnt_full;
            else if (!w_tick)     r_cnt <= r_cnt - 1'b1;
            if (w_bit_clr)        r_bit <= 3'd0;
            else if (w_shift)     r_bit <= r_bit + 1'b1;
            if (w_shift)          r_shift <= {r_rx_s, r_shift[7:1]};
`ifdef UART_RX_PARITY_EN
            // Even parity: the parity bit must equal the XOR of the data bits.
            if (w_par_sample)     r_par_bad <= r_rx_s ^ (^r_shift);
`endif
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_pop_ok    = rd_en && (count != '0);
    assign w_wr_ok     = w_push && ((count != c_depth) || rd_en);
    assign w_ovf       = w_push && (count == c_depth) && !rd_en;
    assign w_count_nxt = count + c_cnt_bits'(w_wr_ok) - c_cnt_bits'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
        end else begin
            if (w_wr_ok)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (rd_en) begin
                rdata       <= w_pop_ok ? r_mem[r_rd_ptr] : 8'h00;
                rdata_valid <= w_pop_ok;
            end
            count <= w_count_nxt;
            empty <= (w_count_nxt == '0);
            full  <= (w_count_nxt == c_depth);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (w_ovf)         overrun    <= 1'b1;
            else if (clr_err)  overrun    <= 1'b0;
            if (w_set_fe)      frame_err  <= 1'b1;
            else if (clr_err)  frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (w_par_sample && (r_rx_s ^ (^r_shift))) parity_err <= 1'b1;
            else if (clr_err)                            parity_err <= 1'b0;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Bench for uart_rx_fifo: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_fifo;
    localparam int DIV   = 10;
    localparam int DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam int NPAR  = 1;
`else
    localparam int NPAR  = 0;
`endif
    localparam int NBITS = 10 + NPAR;
    // Start edge to stop-bit sample: 2 sync flops, 1 detect cycle, half a bit, data bits.
    localparam int LAT   = (9 + NPAR) * DIV + DIV / 2 + 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic [3:0] count;
    logic       empty, full, overrun, frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_fifo #(.CLK_FREQ_HZ(10_000_000), .BAUD_RATE(1_000_000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
        .rdata(rdata), .rdata_valid(rdata_valid), .count(count), .empty(empty),
        .full(full), .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit started = 1'b0;
    bit chk_err = 1'b1;

    logic [7:0] m_q[$];
    logic [7:0] m_rdata = 8'h00;
    bit         m_valid, m_ov, m_fe, m_pe;
    logic [7:0] ev_push [int];
    bit         ev_fe   [int];
    bit         ev_pe   [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: events scheduled by the frame sender, FIFO as a queue.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!resetn) begin
                m_q.delete();
                m_rdata = 8'h00; m_valid = 0; m_ov = 0; m_fe = 0; m_pe = 0;
                started = 1'b1;
            end else begin
                if (rd_en) begin
                    if (m_q.size() > 0) begin m_rdata = m_q.pop_front(); m_valid = 1; end
                    else begin m_rdata = 8'h00; m_valid = 0; end
                end
                if (clr_err) begin m_ov = 0; m_fe = 0; m_pe = 0; end
                if (ev_push.exists(cyc)) begin
                    if (m_q.size() < DEPTH) m_q.push_back(ev_push[cyc]);
                    else m_ov = 1;
                end
                if (ev_fe.exists(cyc)) m_fe = 1;
                if (ev_pe.exists(cyc)) m_pe = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("rdata",       rdata,       m_rdata);
            check("rdata_valid", rdata_valid, m_valid);
            check("count",       count,       m_q.size());
            check("empty",       empty,       m_q.size() == 0);
            check("full",        full,        m_q.size() == DEPTH);
            check("overrun",     overrun,     m_ov);
            if (chk_err) check("frame_err", frame_err, m_fe);
`ifdef UART_RX_PARITY_EN
            check("parity_err",  parity_err,  m_pe);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pop();
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
    endtask

    task automatic clr();
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
    endtask

    // strobe[0]: pop, strobe[1]: clr_err, both on the stop-sample edge.
    task automatic send(input logic [7:0] b, input logic stop_bit, input logic par_bit,
                        input int strobe, input int abort_at);
        logic [10:0] bits;
        int          k;
        bit          par_ok;
        k      = cyc;
        bits   = '1;
        bits[0] = 1'b0;
        bits[8:1] = b;
        bits[9] = par_bit;
        bits[NBITS-1] = stop_bit;
        par_ok = (NPAR == 0) || (par_bit == ^b);
        if (stop_bit && par_ok) ev_push[k+LAT] = b;
        if (!stop_bit)          ev_fe[k+LAT] = 1'b1;
        if (!par_ok)            ev_pe[k+LAT-DIV] = 1'b1;
        for (int j = 0; j < NBITS * DIV; j++) begin
            if (j == abort_at) begin
                if (ev_push.exists(k+LAT))   ev_push.delete(k+LAT);
                if (ev_fe.exists(k+LAT))     ev_fe.delete(k+LAT);
                if (ev_pe.exists(k+LAT-DIV)) ev_pe.delete(k+LAT-DIV);
                rd_en = 1'b0; clr_err = 1'b0;
                return;
            end
            rxd     = bits[j / DIV];
            rd_en   = strobe[0] && (j == LAT - 1);
            clr_err = strobe[1] && (j == LAT - 1);
            tick(1);
        end
        rd_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, 1'b1, ^b, 0, -1);
    endtask

    initial begin
        resetn = 1'b0; rxd = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(50);
        check("idle_count", count, 0);
        check("idle_empty", empty, 1);
        check("idle_valid", rdata_valid, 0);
        check("idle_flags", {overrun, frame_err}, 0);

        send_ok(8'hA5);
        check("a5_count", count, 1);
        pop();
        check("a5_rdata", rdata, 8'hA5);
        check("a5_valid", rdata_valid, 1);
        check("a5_count_after", count, 0);

        send(8'h11, 1'b1, ^8'h11, 1, -1);
        check("empty_pushpop_valid", rdata_valid, 0);
        check("empty_pushpop_rdata", rdata, 0);
        check("empty_pushpop_count", count, 1);
        pop();
        check("empty_pushpop_byte", rdata, 8'h11);

        for (int i = 0; i < 9; i++) send_ok(8'(i));
        check("ovf_full", full, 1);
        check("ovf_flag", overrun, 1);
        for (int i = 0; i < 8; i++) begin
            pop();
            check("ovf_order", rdata, i);
        end
        pop();
        check("underflow_valid", rdata_valid, 0);
        check("underflow_rdata", rdata, 0);
        clr();
        check("ovf_cleared", overrun, 0);

        for (int i = 0; i < 8; i++) send_ok(8'h40 + 8'(i));
        send(8'h48, 1'b1, ^8'h48, 1, -1);
        check("full_pushpop_rdata", rdata, 8'h40);
        check("full_pushpop_count", count, 8);
        check("full_pushpop_ovf", overrun, 0);
        for (int i = 1; i <= 8; i++) begin
            pop();
            check("full_pushpop_order", rdata, 8'h40 + i);
        end
        check("drained_empty", empty, 1);

        rxd = 1'b0; tick(3); rxd = 1'b1; tick(30);
        check("false_start_count", count, 0);
        check("false_start_fe", frame_err, 0);

        send(8'h55, 1'b0, ^8'h55, 0, -1);
        check("bad_stop_fe", frame_err, 1);
        check("bad_stop_count", count, 0);
        tick(50);
        clr();
        check("fe_cleared", frame_err, 0);
        tick(150);
        check("arm_hold_fe", frame_err, 0);
        check("arm_hold_count", count, 0);
        rxd = 1'b1; tick(20);
        send_ok(8'h3C);
        check("post_arm_count", count, 1);
        pop();
        check("post_arm_rdata", rdata, 8'h3C);

        send(8'h66, 1'b0, ^8'h66, 2, -1);
        rxd = 1'b1;
        check("fe_set_wins", frame_err, 1);
        tick(20);
        clr();
        check("fe_clr", frame_err, 0);

        send_ok(8'h01);
        send_ok(8'h02);
        check("pre_reset_count", count, 2);
        send(8'h5A, 1'b1, ^8'h5A, 0, 5 * DIV + DIV / 2);
        rxd = 1'b0; resetn = 1'b0; chk_err = 1'b0;
        tick(1);
        resetn = 1'b1;
        check("reset_count", count, 0);
        check("reset_empty", empty, 1);
        check("reset_valid", rdata_valid, 0);
        tick(120);
        check("no_spurious", count, 0);
        rxd = 1'b1; tick(30);
        clr();
        chk_err = 1'b1;
        check("reset_fe_clear", frame_err, 0);
        send_ok(8'h5A);
        pop();
        check("reset_recover", rdata, 8'h5A);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 0, -1);
        check("par_good_count", count, 1);
        check("par_good_err", parity_err, 0);
        pop();
        check("par_good_rdata", rdata, 8'h07);
        send(8'h07, 1'b1, 1'b0, 0, -1);
        check("par_bad_count", count, 0);
        check("par_bad_err", parity_err, 1);
        clr();
        check("par_clr", parity_err, 0);
`endif

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Memory-mapped UART receiver for the RXD pin, which currently has no consumer; it sits in the SOC IO page beside the TX emitter.
- Deserialises 8N1 frames at a fixed baud rate and buffers bytes in a small FIFO.
- Gives the CPU a registered, pop-on-read data word plus live status.
- Read via the IO_rdata mux; the CPU polls status, then loads the data word.

Parameters:
CLK_FREQ_HZ, 10000000, clk frequency in Hz
BAUD_RATE, 1000000, serial bit rate; DIV = CLK_FREQ_HZ/BAUD_RATE (integer, >= 4)
FIFO_DEPTH, 8, byte entries; power of 2, >= 2

Ports:
clk  input  1  system clock
resetn  input  1  synchronous, active-low reset
rxd  input  1  asynchronous serial line, idle high
rd_en  input  1  one-cycle pop strobe (IO data word read)
clr_err  input  1  one-cycle strobe clearing sticky error flags
rdata  output  8  popped byte, registered
rdata_valid  output  1  1 if the last pop returned a byte
count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
empty  output  1  count == 0
full  output  1  count == FIFO_DEPTH
overrun  output  1  sticky: byte dropped because FIFO full
frame_err  output  1  sticky: stop bit sampled low

Behaviour:
- Reset (resetn low at a clk edge):
  - Synchroniser flops = 1; FSM = ARM; FIFO pointers = 0.
  - rdata = 0, rdata_valid = 0, count = 0, empty = 1, full = 0, overrun = 0, frame_err = 0.
  - Reset mid-frame discards the partial byte and all buffered bytes.
- rxd passes a 2-flop synchroniser; the FSM uses the synchronised value rx_s (2-cycle input latency).
- Bit counter: counts DIV-1 down to 0.
- FSM:
  - ARM: wait until rx_s == 1, then -> IDLE. Prevents mis-framing after reset or a frame error.
  - IDLE: rx_s == 0 -> START; load counter with DIV/2 - 1.
  - START: at counter 0, resample.
    - rx_s == 1: false start -> IDLE.
    - rx_s == 0: -> DATA; counter = DIV-1; bit index = 0.
  - DATA: at each counter expiry, shift rx_s into the shift register LSB-first. After bit 7 -> STOP; counter = DIV-1.
  - STOP: at counter expiry, sample rx_s.
    - 1: push byte -> IDLE.
    - 0: set frame_err, discard byte -> ARM.
- Push:
  - If full and no pop in the same cycle: byte dropped, overrun set, FIFO unchanged.
  - Push and pop in the same cycle when full: both occur; count unchanged; no overrun.
  - Push and pop in the same cycle when empty: pop sees empty (rdata_valid = 0); push lands; count = 1.
- Pop (rd_en):
  - Next cycle: rdata = head byte and rdata_valid = 1 if FIFO non-empty, else rdata = 0 and rdata_valid = 0.
  - rdata holds until the next rd_en.
  - Pointers wrap modulo FIFO_DEPTH.
- count, empty and full are registered and reflect the cycle after a push or pop.
- clr_err clears overrun and frame_err. If a set event occurs in the same cycle, set wins.
- Latency: rdata_valid/count update 1 cycle after the STOP-bit sample, i.e. roughly 9.5 bit periods + 3 cycles after the start edge.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples one extra bit.
  - The sampled bit is compared against even parity (XOR of data bits).
  - Mismatch sets output parity_err (sticky, 1 bit, reset 0, cleared by clr_err) and the byte is discarded; STOP is still sampled.
- Undefined: no PARITY state; parity_err port absent; 8N1 only.

Test Plan:
- Reset then idle rxd=1 for 50 cycles -> count=0, empty=1, rdata_valid=0, all flags 0.
- Send 0xA5 (DIV=10, 100-cycle frame), then pulse rd_en -> count 0->1 after frame; next cycle after rd_en rdata=0xA5, rdata_valid=1, count=0.
- Send 9 bytes 0x00..0x08 back-to-back without reads (DEPTH=8) -> full=1, overrun=1. Eight pops return 0x00..0x07 in order; a ninth pop gives rdata_valid=0, rdata=0.
- rxd low pulse of 3 cycles -> false start, no push, count=0. Then a frame with stop bit=0 -> frame_err=1, no push. Byte 0x3C sent while rxd is held low until 20 cycles before it is not received. Next valid 0x3C is received; clr_err -> frame_err=0.
- Assert resetn low at bit 4 of 0x5A with 2 bytes buffered -> count=0, empty=1 next cycle. Line stays low mid-frame -> ARM holds, no spurious byte. Next full frame 0x5A is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity bit 1 -> pushed, parity_err=0. Same byte with parity bit 0 -> not pushed, parity_err=1.
